// File: rtl/uart16550_pkg.sv
// Shared UART16550 types: line control register, Rx FIFO entry and receiver state.
package uart16550_pkg;

    localparam int unsigned RX_OVERSAMPLE   = 16;
    localparam int unsigned RX_START_SAMPLE = 8;
    localparam int unsigned RX_CNT_W        = $clog2(RX_OVERSAMPLE);
    localparam int unsigned RX_DATA_W       = 8;
    localparam int unsigned RX_IDX_W        = $clog2(RX_DATA_W);

    typedef enum logic [1:0] {
        WLS_5 = 2'd0,
        WLS_6 = 2'd1,
        WLS_7 = 2'd2,
        WLS_8 = 2'd3
    } wls_t;

    typedef enum logic {
        EPS_ODD  = 1'b0,
        EPS_EVEN = 1'b1
    } eps_t;

    typedef struct packed {
        logic dlab;
        logic set_break;
        logic stick_parity;
        eps_t eps;
        logic pen;
        logic stb;
        wls_t wls;
    } lcr_t;

    typedef struct packed {
        logic                 bi;
        logic                 fe;
        logic                 pe;
        logic [RX_DATA_W-1:0] d;
    } rx_d_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // Index of the last data bit for a given word length (5..8 bits).
    function automatic logic [RX_IDX_W-1:0] rx_last_idx(input wls_t wls);
        return RX_IDX_W'(3'd4 + 3'(wls));
    endfunction

endpackage

// File: rtl/uart16550_sync.sv
// N-flop synchroniser for asynchronous single-bit inputs (sin, modem lines).
module uart16550_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift chain; reset to the line's idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart16550_rx.sv
// UART16550 serial receiver: 16x oversampled deserialiser with parity/framing/break
// checks, one Rx FIFO push per character.
// Optional: define UART16550_RX_MAJORITY_VOTE_EN for 2-of-3 majority bit sampling.
module uart16550_rx
    import uart16550_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic  PCLK,
    input  logic  PRESETn,
    input  logic  rx_tick,
    input  logic  sin,
    input  lcr_t  lcr,
    output logic  rx_push,
    output rx_d_t rx_d,
    output logic  rx_busy
);

    rx_state_t             state_q, state_d;
    logic [RX_CNT_W-1:0]   cnt_q, cnt_d;
    logic [RX_IDX_W-1:0]   idx_q, idx_d;
    logic [RX_DATA_W-1:0]  shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  pe_q, pe_d;
    lcr_t                  frame_q, frame_d;
    logic                  push_q, push_d;
    rx_d_t                 rxd_q, rxd_d;
    logic                  busy_q;

    logic sin_s;
    logic samp;
    logic sample;
    logic par_exp;
    logic brk;
    logic unused_lcr;

    uart16550_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .d     (sin),
        .q     (sin_s)
    );

`ifdef UART16550_RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q;

    // Last two tick-sampled line values, feeding the 2-of-3 vote.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            hist_q <= 2'b11;
        end else if (rx_tick) begin
            hist_q <= {hist_q[0], sin_s};
        end
    end

    assign samp = (sin_s & hist_q[0]) | (sin_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign samp = sin_s;
`endif

    assign sample  = (cnt_q == RX_CNT_W'(RX_START_SAMPLE - 1));
    assign par_exp = frame_q.stick_parity ? (frame_q.eps == EPS_ODD)
                                          : ((^shreg_q) ^ (frame_q.eps == EPS_ODD));
    assign brk     = ~samp & ~par_q & (shreg_q == '0);

    assign unused_lcr = ^{frame_q.dlab, frame_q.set_break, frame_q.stb};

    // State and datapath registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
            frame_q <= '0;
            push_q  <= 1'b0;
            rxd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            pe_q    <= pe_d;
            frame_q <= frame_d;
            push_q  <= push_d;
            rxd_q   <= rxd_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Next-state and datapath updates; all decisions happen on rx_tick only.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        pe_d    = pe_q;
        frame_d = frame_q;
        push_d  = 1'b0;
        rxd_d   = rxd_q;

        if (rx_tick) begin
            cnt_d = RX_CNT_W'(cnt_q + 1'b1);
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!sin_s) begin
                        state_d = START;
                        frame_d = lcr;
                        shreg_d = '0;
                        idx_d   = '0;
                        par_d   = 1'b0;
                        pe_d    = 1'b0;
                    end
                end
                START: begin
                    if (sample) begin
                        state_d = samp ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg_d[idx_q] = samp;
                        idx_d          = RX_IDX_W'(idx_q + 1'b1);
                        if (idx_q == rx_last_idx(frame_q.wls)) begin
                            state_d = frame_q.pen ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (sample) begin
                        par_d   = samp;
                        pe_d    = (samp != par_exp);
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (sample) begin
                        push_d   = 1'b1;
                        rxd_d.bi = brk;
                        rxd_d.fe = ~samp;
                        rxd_d.pe = pe_q;
                        rxd_d.d  = shreg_q;
                        state_d  = brk ? BREAK : IDLE;
                    end
                end
                BREAK: begin
                    cnt_d = '0;
                    if (sin_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign rx_push = push_q;
    assign rx_d    = rxd_q;
    assign rx_busy = busy_q;

endmodule

// File: tb/tb_uart16550_rx.sv
// Self-checking bench for uart16550_rx: frame-level model plus per-cycle output compare.
module tb_uart16550_rx;

    logic        PCLK;
    logic        PRESETn;
    logic        rx_tick;
    logic        sin;
    logic [7:0]  lcr;
    logic        rx_push;
    logic [10:0] rx_d;
    logic        rx_busy;

    int checks;
    int errors;
    int tick_no;
    time last_tick_time;

    typedef struct {
        logic [10:0] d;
        int          tick;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] last_exp;

    uart16550_rx #(.SYNC_STAGES(2)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .rx_tick (rx_tick),
        .sin     (sin),
        .lcr     (lcr),
        .rx_push (rx_push),
        .rx_d    (rx_d),
        .rx_busy (rx_busy)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // 16x tick: one PCLK cycle high every 4 cycles; tick_no counts tick edges.
    initial begin
        rx_tick        = 1'b0;
        tick_no        = 0;
        last_tick_time = 0;
        forever begin
            repeat (3) @(posedge PCLK);
            #1 rx_tick = 1'b1;
            @(posedge PCLK);
            tick_no++;
            last_tick_time = $time;
            #1 rx_tick = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected FIFO entry from the serial bits on the wire.
    function automatic logic [10:0] model(input logic [7:0] cfg, input logic [7:0] data,
                                          input logic par, input logic stop);
        int         nd;
        int         ones;
        logic [7:0] d;
        logic       pen, eps, stick, exp_par, pe, fe, bi;
        nd      = 5 + int'(cfg[1:0]);
        d       = 8'(int'(data) & ((1 << nd) - 1));
        pen     = cfg[3];
        eps     = cfg[4];
        stick   = cfg[5];
        ones    = $countones(d);
        if (stick)     exp_par = !eps;
        else if (eps)  exp_par = (ones % 2 == 1);
        else           exp_par = (ones % 2 == 0);
        pe      = pen && (par != exp_par);
        fe      = !stop;
        bi      = (d == 8'h00) && (!pen || !par) && !stop;
        return {bi, fe, pe, d};
    endfunction

    // Drive one bit for 16 ticks; optional inversion on the mid-bit sample tick only.
    task automatic drive_bit(input logic b, input logic glitch, output int k);
        @(posedge PCLK iff rx_tick);
        #1;
        k   = tick_no;
        sin = b;
        for (int t = 1; t < 16; t++) begin
            @(posedge PCLK iff rx_tick);
            #1;
            sin = (glitch && t == 8) ? ~b : b;
        end
    endtask

    task automatic send_frame(input logic [7:0] cfg, input logic [7:0] data, input logic par,
                              input logic stop, input int glitch_bit, input int gap_bits);
        int   nd;
        int   nbits;
        int   k;
        int   kd;
        exp_t e;
        nd    = 5 + int'(cfg[1:0]);
        nbits = 1 + nd + (cfg[3] ? 1 : 0) + 1;
        lcr   = cfg;
        drive_bit(1'b0, 1'b0, k);
        e.d    = model(cfg, data, par, stop);
        e.tick = k + 1 + 8 + 16 * (nbits - 1);
        exp_q.push_back(e);
        for (int i = 0; i < nd; i++) begin
            drive_bit(data[i], glitch_bit == i, kd);
            if (i == 0) chk("busy_in_frame", 32'(rx_busy), 32'd1);
        end
        if (cfg[3]) drive_bit(par, 1'b0, kd);
        drive_bit(stop, 1'b0, kd);
        for (int g = 0; g < gap_bits; g++) drive_bit(1'b1, 1'b0, kd);
    endtask

    task automatic frame_result(input string name, input logic [10:0] lit);
        chk(name, 32'(rx_d), 32'(lit));
        chk({name, "_idle"}, 32'(rx_busy), 32'd0);
    endtask

    initial begin
        int   kd;
        int   k;
        exp_t e;
        checks   = 0;
        errors   = 0;
        PRESETn  = 1'b0;
        sin      = 1'b1;
        lcr      = 8'h03;
        last_exp = '0;

        // Per-cycle compare: every push matches the next modelled entry at its tick; rx_d holds between pushes.
        fork
            forever begin
                exp_t c;
                @(negedge PCLK);
                if (rx_push) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_push", 32'(rx_d), 32'h7ff);
                        if (rx_d == 11'h7ff) chk("unexpected_push", 32'd1, 32'd0);
                    end else begin
                        c        = exp_q.pop_front();
                        last_exp = c.d;
                        chk("push_tick", 32'(tick_no), 32'(c.tick));
                        chk("push_phase", 32'($time - last_tick_time), 32'd5);
                    end
                end
                chk("rx_d_track", 32'(rx_d), 32'(last_exp));
            end
        join_none

        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset_push", 32'(rx_push), 32'd0);
        chk("reset_busy", 32'(rx_busy), 32'd0);
        chk("reset_rx_d", 32'(rx_d), 32'd0);
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        repeat (8) @(posedge PCLK);

        send_frame(8'h03, 8'hA5, 1'b0, 1'b1, -1, 2);
        frame_result("8n1_a5", 11'h0A5);

        send_frame(8'h1A, 8'h41, 1'b1, 1'b1, -1, 2);
        frame_result("7e1_41_p1", 11'h141);
        send_frame(8'h1A, 8'h41, 1'b0, 1'b1, -1, 2);
        frame_result("7e1_41_p0", 11'h041);

        send_frame(8'h38, 8'h1F, 1'b0, 1'b1, -1, 2);
        frame_result("5s1_1f_p0", 11'h01F);
        send_frame(8'h38, 8'h1F, 1'b1, 1'b1, -1, 2);
        frame_result("5s1_1f_p1", 11'h11F);

        send_frame(8'h0B, 8'h07, 1'b0, 1'b1, -1, 2);
        frame_result("8o1_07", 11'h007);

        send_frame(8'h01, 8'h2A, 1'b0, 1'b1, -1, 2);
        frame_result("6n1_2a", 11'h02A);

        send_frame(8'h03, 8'h3C, 1'b0, 1'b0, -1, 1);
        frame_result("8n1_3c_fe", 11'h23C);
        send_frame(8'h03, 8'h81, 1'b0, 1'b1, -1, 2);
        frame_result("resync_81", 11'h081);

        // Break: line low for three frame times, then released.
        lcr = 8'h03;
        drive_bit(1'b0, 1'b0, k);
        e.d    = model(8'h03, 8'h00, 1'b0, 1'b0);
        e.tick = k + 1 + 8 + 16 * 9;
        exp_q.push_back(e);
        for (int i = 0; i < 29; i++) drive_bit(1'b0, 1'b0, kd);
        chk("break_busy", 32'(rx_busy), 32'd1);
        for (int i = 0; i < 2; i++) drive_bit(1'b1, 1'b0, kd);
        frame_result("break", 11'h600);
        send_frame(8'h03, 8'h55, 1'b0, 1'b1, -1, 2);
        frame_result("after_break_55", 11'h055);

        // Short low pulse: false start, no push.
        @(posedge PCLK iff rx_tick);
        #1 sin = 1'b0;
        @(posedge PCLK iff rx_tick);
        @(posedge PCLK iff rx_tick);
        #1;
        chk("false_start_busy", 32'(rx_busy), 32'd1);
        @(posedge PCLK iff rx_tick);
        #1 sin = 1'b1;
        repeat (20) @(posedge PCLK iff rx_tick);
        #1;
        chk("false_start_idle", 32'(rx_busy), 32'd0);
        chk("false_start_rx_d", 32'(rx_d), 32'h055);

`ifdef UART16550_RX_MAJORITY_VOTE_EN
        send_frame(8'h03, 8'h00, 1'b0, 1'b1, 2, 2);
        frame_result("vote_glitch", 11'h000);
`endif

        // Reset in the middle of a character.
        send_frame(8'h03, 8'hA5, 1'b0, 1'b1, -1, 2);
        frame_result("pre_reset_a5", 11'h0A5);
        lcr = 8'h03;
        drive_bit(1'b0, 1'b0, kd);
        drive_bit(1'b1, 1'b0, kd);
        drive_bit(1'b0, 1'b0, kd);
        chk("mid_frame_busy", 32'(rx_busy), 32'd1);
        last_exp = '0;
        PRESETn  = 1'b0;
        #2;
        chk("mid_reset_push", 32'(rx_push), 32'd0);
        chk("mid_reset_busy", 32'(rx_busy), 32'd0);
        chk("mid_reset_rx_d", 32'(rx_d), 32'd0);
        sin = 1'b1;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        repeat (160) @(posedge PCLK);
        chk("post_reset_idle", 32'(rx_busy), 32'd0);
        send_frame(8'h03, 8'hC3, 1'b0, 1'b1, -1, 2);
        frame_result("post_reset_c3", 11'h0C3);

        repeat (20) @(posedge PCLK);
        chk("pending_pushes", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart16550_rx.md
Name: uart16550_rx

Overview:
- Serial receiver for the UART16550. Deserialises `sin` using the 16x oversampling enable from the baud generator.
- Frame format (5–8 data bits, parity, stop bits) comes from the current LCR fields.
- Checks parity, framing and break, then pushes one `rx_d_t` entry per character into the Rx FIFO.
- Sits between the pad/loopback mux and the Rx FIFO. It has no CSR access of its own. Overrun is handled by the FIFO/LSR logic.

Parameters:
- `SYNC_STAGES`, default 2: number of flip-flops in the `sin` synchroniser, minimum 2.

Ports:
- `PCLK` input 1: system clock, all logic rising-edge.
- `PRESETn` input 1: asynchronous active-low reset.
- `rx_tick` input 1: one-PCLK pulse at 16x baud rate.
- `sin` input 1: serial input, asynchronous, idles high.
- `lcr` input 8: `lcr_t`; uses `wls`, `pen`, `eps`, `stick_parity`. `dlab`, `set_break` and `stb` are ignored (only the first stop bit is checked).
- `rx_push` output 1: one-cycle push strobe to the Rx FIFO.
- `rx_d` output 11: `rx_d_t` {`bi`, `fe`, `pe`, `d[7:0]`}, valid while `rx_push`=1.
- `rx_busy` output 1: high from start-bit detect until return to IDLE.

Behaviour:
- Clock and reset: one clock, `PCLK`; reset `PRESETn` is asynchronous, active-low.
- Reset values:
  - synchroniser flops = 1; state = IDLE; tick counter = 0; shift register = 0.
  - `rx_push`=0, `rx_d`=0, `rx_busy`=0.
- Reset mid-frame aborts the character; no push occurs.
- `sin_s` is `sin` after `SYNC_STAGES` flops. All decisions use `sin_s`, and only on `rx_tick` cycles. With no `rx_tick`, the state holds.
- Sample point:
  - START: 8th `rx_tick` after the detecting tick.
  - Every later bit: 16th `rx_tick` after the previous sample.
- State machine:
  - IDLE: on `rx_tick` with `sin_s`=0, go to START. Also latch `lcr` into a frame-local copy; `lcr` changes mid-frame take effect on the next frame.
  - START: at the sample point, if `sin_s`=1 it is a false start: go to IDLE, no push. Otherwise go to DATA, bit index 0.
  - DATA: shift `sin_s` in LSB-first. Number of bits = 5 + `wls`. After the last bit, go to PARITY if `pen`, else STOP. Unused upper bits of `d` are 0.
  - PARITY: compute the expected parity bit, then set `pe` = (sampled bit != expected):
    - `stick_parity`=1: expected = ~`eps`.
    - `stick_parity`=0: expected = ^data, XORed with 1 when `eps`=odd.
  - STOP:
    - `fe` = (`sin_s`==0).
    - `bi` = 1 if data bits, parity bit (if any) and stop bit were all 0. When `bi`=1, `d`=0 and `fe`=1.
    - Push the entry. Next state is BREAK if `bi`, else IDLE.
  - BREAK: wait for an `rx_tick` with `sin_s`=1, then go to IDLE. No new start is accepted while waiting, so one push per break.
- Push timing:
  - `rx_push` is registered and asserts the PCLK cycle after the stop-bit sample tick, for exactly 1 cycle.
  - `rx_d` holds its value until the next push.
- Framing-error resync: after a push with `fe`=1 and `bi`=0, IDLE sees `sin_s`=0 on the next tick and starts a new frame immediately (16550-style resync).
- FIFO full is not visible here; the push always occurs.
- `rx_busy`=0 in IDLE only.
- Tick counter is 4 bits and wraps 15→0 naturally at each 16-tick bit boundary.

Optional Feature:
- Macro `UART16550_RX_MAJORITY_VOTE_EN`.
- Defined: each bit value is the 2-of-3 majority of `sin_s` at the sample tick and the two preceding `rx_tick`s. This applies to START, DATA, PARITY and STOP. A single-tick glitch at mid-bit is rejected.
- Undefined: single sample at the sample tick only.
- Sample timing, latency and ports are identical in both builds.

Decomposition:
- Additions to `uart16550_pkg`:
  - `rx_state_t` enum {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - `RX_OVERSAMPLE`=16 and `RX_START_SAMPLE`=8.
- Reuses the existing `lcr_t`, `wls_t`, `eps_t` and `rx_d_t`.
- One sub-module: `uart16550_sync`, a parameterised N-flop synchroniser with reset value 1 for `sin`. It is reusable for the modem inputs.

Test Plan:
- 8N1, `sin` = 0xA5 LSB-first, 16 ticks/bit → one `rx_push`, `rx_d`={0,0,0,8'hA5}, asserted 1 cycle after the stop sample.
- 7E1, data 0x41 with parity bit driven 1 → `rx_d`={0,0,1,8'h41}. Repeat with parity 0 → `pe`=0.
- 5-bit, stick parity, `eps`=1, data 0x1F, parity bit 0 → `d`=8'h1F, `pe`=0. Parity 1 → `pe`=1.
- 8N1 with stop bit 0, data 0x3C → `fe`=1, `bi`=0, `d`=8'h3C. A new frame starting immediately after is received correctly.
- `sin` held low for 3 frame times, then high → exactly one push {1,1,0,8'h00}. Then an 0x55 frame → normal push.
- 3-tick low pulse on idle line → no push, `rx_busy` returns to 0. With the macro defined, a 1-tick high glitch at a data mid-bit is ignored. Also assert `PRESETn` mid-frame → no push, all outputs 0.
